// File: rtl/filter_frame_ctrl.sv
// Frame sequencer feeding a free-running filter_unit: clears it, streams tagged pixels gap-free,
// then waits for the end-of-frame tag at the filter output. Optional abort input: FILTER_CTRL_ABORT_EN.
module filter_frame_ctrl #(
  parameter int                   TAG_WIDTH    = 2,
  parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = TAG_WIDTH'(0),
  parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = TAG_WIDTH'(1),
  parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = TAG_WIDTH'(2),
  parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = TAG_WIDTH'(3),
  parameter int                   OPE_WIDTH    = 3,
  parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH,
  parameter int                   DRAIN_MAX    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9:0]            cfg_width,
  input  logic [9:0]            cfg_height,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  output logic                  err_underrun,
  output logic                  err_timeout,
  input  logic [DATA_WIDTH-TAG_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] flt_data_in,
  output logic [9:0]            flt_image_width,
  output logic                  flt_reflesh,
  input  logic [DATA_WIDTH-1:0] flt_data_out
`ifdef FILTER_CTRL_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int PIX_W = DATA_WIDTH - TAG_WIDTH;
  localparam int DW    = $clog2(DRAIN_MAX + 1);
  localparam logic [9:0]            OPE_W        = 10'(OPE_WIDTH);
  localparam logic [DW-1:0]         DRAIN_TOP    = DW'(DRAIN_MAX);
  localparam logic [DATA_WIDTH-1:0] INVALID_WORD = {INVALID_TAG, {PIX_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [9:0]              w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
  logic [9:0]              width_q, width_d;
  logic [DW-1:0]           drain_q, drain_d, drain_inc;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    refl_q, refl_d, done_q, done_d;
  logic                    ecfg_q, ecfg_d, eund_q, eund_d, eto_q, eto_d;
  logic [TAG_WIDTH-1:0]    out_tag, pix_tag;
  logic                    last_pix, first_pix;
  logic                    unused_out_pix;

  assign out_tag        = flt_data_out[DATA_WIDTH-1 -: TAG_WIDTH];
  assign unused_out_pix = ^flt_data_out[PIX_W-1:0];
  assign last_pix       = (row_q == h_q - 10'd1) && (col_q == w_q - 10'd1);
  assign first_pix      = (row_q == 10'd0) && (col_q == 10'd0);
  assign pix_tag        = last_pix ? DATA_END_TAG : (row_q[0] ? DATA_TAG1 : DATA_TAG0);
  assign drain_inc      = drain_q + DW'(1);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    row_d   = row_q;
    col_d   = col_q;
    width_d = width_q;
    drain_d = drain_q;
    data_d  = INVALID_WORD;
    refl_d  = 1'b0;
    done_d  = 1'b0;
    ecfg_d  = ecfg_q;
    eund_d  = eund_q;
    eto_d   = eto_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_width < OPE_W || cfg_height < OPE_W) begin
            ecfg_d = 1'b1;
          end else begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            width_d = cfg_width;
            row_d   = '0;
            col_d   = '0;
            drain_d = '0;
            ecfg_d  = 1'b0;
            eund_d  = 1'b0;
            eto_d   = 1'b0;
            refl_d  = 1'b1;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: state_d = STREAM;
      STREAM: begin
        if (src_valid) begin
          data_d = {pix_tag, src_data};
          if (last_pix) begin
            drain_d = '0;
            state_d = DRAIN;
          end else if (col_q == w_q - 10'd1) begin
            col_d = '0;
            row_d = row_q + 10'd1;
          end else begin
            col_d = col_q + 10'd1;
          end
        end else if (!first_pix) begin
          // the filter cannot pause, so a mid-frame gap corrupts the window: abandon the frame
          eund_d  = 1'b1;
          refl_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (out_tag == DATA_END_TAG) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (drain_inc == DRAIN_TOP) begin
          eto_d   = 1'b1;
          refl_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FILTER_CTRL_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      refl_d  = 1'b1;
      data_d  = INVALID_WORD;
      done_d  = 1'b0;
      eund_d  = eund_q;
      eto_d   = eto_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      width_q <= '0;
      drain_q <= '0;
      data_q  <= '0;
      refl_q  <= 1'b0;
      done_q  <= 1'b0;
      ecfg_q  <= 1'b0;
      eund_q  <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      row_q   <= row_d;
      col_q   <= col_d;
      width_q <= width_d;
      drain_q <= drain_d;
      data_q  <= data_d;
      refl_q  <= refl_d;
      done_q  <= done_d;
      ecfg_q  <= ecfg_d;
      eund_q  <= eund_d;
      eto_q   <= eto_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign src_ready       = (state_q == STREAM);
  assign done            = done_q;
  assign err_cfg         = ecfg_q;
  assign err_underrun    = eund_q;
  assign err_timeout     = eto_q;
  assign flt_data_in     = data_q;
  assign flt_image_width = width_q;
  assign flt_reflesh     = refl_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Bench for filter_frame_ctrl: random pixels, a delay-line stand-in for filter_unit,
// and a frame-level reference model of tags, pixel counts, pulses and error flags.
module tb_filter_frame_ctrl;
  localparam int DMAX = 16;

  logic       clk = 1'b0;
  logic       rst, start, src_valid, src_ready;
  logic [9:0] cfg_width, cfg_height, flt_data_in, flt_image_width, flt_data_out;
  logic [7:0] src_data;
  logic       busy, done, err_cfg, err_underrun, err_timeout, flt_reflesh;
`ifdef FILTER_CTRL_ABORT_EN
  logic       abort;
`endif
  logic [9:0] pipe [32];
  logic [4:0] tap;
  int         n_pass = 0;
  int         n_chk  = 0;

  filter_frame_ctrl #(.DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .err_underrun(err_underrun), .err_timeout(err_timeout),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .flt_data_in(flt_data_in), .flt_image_width(flt_image_width),
    .flt_reflesh(flt_reflesh), .flt_data_out(flt_data_out)
`ifdef FILTER_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // filter stand-in: pure delay of 'tap+1' cycles, cleared by reflesh
  always @(posedge clk or negedge rst) begin
    if (!rst || flt_reflesh) begin
      for (int i = 0; i < 32; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= flt_data_in;
      for (int i = 1; i < 32; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign flt_data_out = pipe[tap];

  function automatic logic [9:0] exp_word(input int k, input int w, input int h, input logic [7:0] pix);
    logic [1:0] tag;
    if (k == w * h - 1)          tag = 2'd3;
    else if ((k / w) % 2 == 1)   tag = 2'd2;
    else                         tag = 2'd1;
    return {tag, pix};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_ready"},  32'(src_ready), 0);
    chk({tag, "_data"},   32'(flt_data_in), 0);
    chk({tag, "_width"},  32'(flt_image_width), 0);
    chk({tag, "_refl"},   32'(flt_reflesh), 0);
    chk({tag, "_errs"},   32'({err_cfg, err_underrun, err_timeout}), 0);
  endtask

  // kind: 0 done, 1 underrun, 2 timeout, 3 abort
  task automatic run_frame(input int w, input int h, input int gap, input int drop_at,
                           input int lat, input int abort_at, input int kind, input bit start_in_done);
    int   k, stalls, refl, dones, cyc, drain_cyc, stream_cyc, exp_k;
    bit   v, rdy, hs, stall, ab, ended, pend_start;
    logic [7:0] pix;
    k = 0; stalls = 0; dones = 0; cyc = 0; drain_cyc = 0; stream_cyc = 0;
    ended = 0; pend_start = 0;
    tap = 5'(lat - 1);
    cfg_width = 10'(w); cfg_height = 10'(h); start = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_busy",    32'(busy), 1);
    chk("start_reflesh", 32'(flt_reflesh), 1);
    chk("image_width",   32'(flt_image_width), 32'(w));
    chk("errs_cleared",  32'({err_cfg, err_underrun, err_timeout}), 0);
    refl = 1;
    while (busy && cyc < 400) begin
      rdy = src_ready;
      if (pend_start) begin
        start = 1'b1;
        pend_start = 0;
      end
      v = !((k == 0 && stream_cyc < gap) || k == drop_at);
      ab = (k == abort_at) && rdy;
      src_valid = v;
      src_data = 8'($urandom);
      pix = src_data;
`ifdef FILTER_CTRL_ABORT_EN
      abort = ab;
`endif
      hs = v && rdy && !ab;
      stall = rdy && !v && k == 0 && !ab;
      cycle();
      start = 1'b0;
`ifdef FILTER_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      cyc++;
      if (rdy) stream_cyc++;
      if (hs) begin
        chk("word", 32'(flt_data_in), 32'(exp_word(k, w, h, pix)));
        k++;
        if (k == w * h) ended = 1;
      end else if (stall) begin
        chk("invalid_word", 32'(flt_data_in), 0);
        stalls++;
      end else if (ab) begin
        chk("abort_idle", 32'(busy), 0);
        chk("abort_word", 32'(flt_data_in), 0);
      end else if (rdy && !v) begin
        chk("underrun_idle", 32'(busy), 0);
        chk("underrun_word", 32'(flt_data_in), 0);
      end
      if (flt_reflesh) refl++;
      if (done) begin
        dones++;
        pend_start = start_in_done;
      end
      if (ended && busy && !done) drain_cyc++;
    end
    src_valid = 1'b0;
    exp_k = (kind == 1) ? drop_at : (kind == 3) ? abort_at : w * h;
    chk("frame_ended",    32'(busy), 0);
    chk("pixels",         32'(k), 32'(exp_k));
    chk("done_pulses",    32'(dones), 32'(kind == 0));
    chk("reflesh_cycles", 32'(refl), (kind == 0) ? 1 : 2);
    chk("stall_words",    32'(stalls), 32'(gap));
    chk("err_underrun",   32'(err_underrun), 32'(kind == 1));
    chk("err_timeout",    32'(err_timeout), 32'(kind == 2));
    chk("err_cfg",        32'(err_cfg), 0);
    if (kind == 0) chk("drain_to_done", 32'(drain_cyc), 32'(lat + 1));
    if (kind == 2) chk("drain_to_timeout", 32'(drain_cyc), DMAX);
    cycle();
    chk("post_reflesh_low", 32'(flt_reflesh), 0);
    chk("post_idle",        32'(busy), 0);
    chk("post_done_low",    32'(done), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
    cfg_width = '0; cfg_height = '0; tap = 5'd3;
`ifdef FILTER_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) cycle();
    chk_all_zero("reset");
    rst = 1'b1;
    cycle();

    // illegal geometry
    cfg_width = 10'd2; cfg_height = 10'd4; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("badw_err",  32'(err_cfg), 1);
    chk("badw_busy", 32'(busy), 0);
    chk("badw_refl", 32'(flt_reflesh), 0);
    cfg_width = 10'd5; cfg_height = 10'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("badh_err",  32'(err_cfg), 1);
    chk("badh_busy", 32'(busy), 0);
    cycle();
    chk("badh_refl", 32'(flt_reflesh), 0);

    // nominal 8x4 frame, with a start pulse during DONE that must be ignored
    run_frame(8, 4, 0, -1, 4, -1, 0, 1'b1);
    // source idle 5 cycles before first pixel
    run_frame(8, 4, 5, -1, 4, -1, 0, 1'b0);
    // underrun at pixel 12, then a clean frame
    run_frame(8, 4, 0, 12, 4, -1, 1, 1'b0);
    run_frame(8, 4, 0, -1, 6, -1, 0, 1'b0);
    // END never returns in time
    run_frame(8, 4, 0, -1, 31, -1, 2, 1'b0);
    // END on the last allowed drain cycle wins; one cycle later times out
    run_frame(3, 3, 0, -1, DMAX - 1, -1, 0, 1'b0);
    run_frame(3, 3, 0, -1, DMAX, -1, 2, 1'b0);

`ifdef FILTER_CTRL_ABORT_EN
    run_frame(8, 4, 0, -1, 4, 5, 3, 1'b0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_refl", 32'(flt_reflesh), 0);
    chk("idle_abort_errs", 32'({err_cfg, err_underrun, err_timeout}), 0);
`endif

    // asynchronous reset mid-frame
    cfg_width = 10'd8; cfg_height = 10'd4; start = 1'b1;
    cycle();
    start = 1'b0;
    src_valid = 1'b1;
    repeat (6) cycle();
    chk("midframe_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    cycle();
    rst = 1'b1;
    src_valid = 1'b0;
    cycle();
    chk("after_reset_idle", 32'(busy), 0);

    for (int r = 0; r < 3; r++)
      run_frame(int'($urandom_range(3, 10)), int'($urandom_range(3, 5)), int'($urandom_range(0, 3)),
                -1, int'($urandom_range(1, 15)), -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
Frame sequencer in front of filter_unit. Latches the frame geometry and pulses reflesh to clear the filter. It then pulls pixels from an upstream valid/ready source and drives filter_unit.data_in with tagged words. It watches filter_unit.data_out for the end-of-frame tag to declare completion. filter_unit has no enable and shifts every clk, so this block guarantees gap-free lines or aborts the frame.

Parameters:
TAG_WIDTH, 2, tag field width (word MSBs)
INVALID_TAG, 2'd0, tag for non-pixel words
DATA_TAG0, 2'd1, tag for pixels on even rows
DATA_TAG1, 2'd2, tag for pixels on odd rows
DATA_END_TAG, 2'd3, tag for last pixel of frame
OPE_WIDTH, 3, filter window size; minimum legal width/height
DATA_WIDTH, 8+TAG_WIDTH, filter word width
DRAIN_MAX, 4096, max DRAIN cycles before timeout (counter width clog2(DRAIN_MAX+1))

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
start  input  1  frame start request (pulse)
cfg_width  input  10  pixels per line
cfg_height  input  10  lines per frame
busy  output  1  state != IDLE
done  output  1  one-cycle frame-complete pulse
err_cfg  output  1  sticky: illegal geometry on start
err_underrun  output  1  sticky: source stalled mid-frame
err_timeout  output  1  sticky: END tag never seen at filter output
src_data  input  8  pixel
src_valid  input  1  pixel available
src_ready  output  1  pixel accepted when valid&ready
flt_data_in  output  DATA_WIDTH  to filter_unit.data_in, {tag, pixel}
flt_image_width  output  10  to filter_unit.image_width
flt_reflesh  output  1  to filter_unit.reflesh
flt_data_out  input  DATA_WIDTH  from filter_unit.data_out

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0: flt_data_in, flt_image_width, flt_reflesh, src_ready, busy, done, all err_*. Counters 0.
- All outputs registered, except busy and src_ready, which are decoded from state.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE, start=1:
  - Geometry is illegal if cfg_width < OPE_WIDTH or cfg_height < OPE_WIDTH. Illegal: err_cfg<=1, stay IDLE.
  - Legal: latch width/height, clear all err_*, flt_image_width<=width (held until next accepted start), go CLEAR.
- start is ignored outside IDLE.
- CLEAR (1 cycle): flt_reflesh=1, flt_data_in=0, go STREAM.
- STREAM: src_ready=1.
  - Handshake (valid&ready): next cycle flt_data_in={tag,src_data}.
    - tag = DATA_END_TAG if row==h-1 and col==w-1.
    - Otherwise DATA_TAG0 for even row, DATA_TAG1 for odd row.
  - Latency src→flt_data_in: 1 cycle.
  - col wraps at w-1 to 0 with row+1. After the END pixel, go DRAIN.
  - src_valid=0 before the first pixel (row=0,col=0): flt_data_in<=0 (INVALID); wait indefinitely, no error.
  - src_valid=0 after the first pixel: underrun.
    - err_underrun<=1, flt_data_in<=0, flt_reflesh pulsed 1 cycle, go IDLE.
    - No done pulse.
- DRAIN: src_ready=0, flt_data_in=0 every cycle, drain counter increments.
  - flt_data_out[DATA_WIDTH-1 -: TAG_WIDTH]==DATA_END_TAG: go DONE.
  - Counter reaches DRAIN_MAX first: err_timeout<=1, flt_reflesh pulsed, go IDLE.
  - If END is seen in the same cycle the counter reaches DRAIN_MAX, END wins.
- DONE: done=1 for one cycle, go IDLE. A start arriving in the DONE cycle is ignored.
- Reset asserted mid-frame returns to IDLE immediately, with all outputs at reset values.

Optional Feature:
FILTER_CTRL_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 in CLEAR/STREAM/DRAIN/DONE:
  - next cycle state IDLE, flt_reflesh=1 for 1 cycle, flt_data_in=0, src_ready=0.
  - No done, no err_* change.
  - abort has priority over underrun/timeout/END in the same cycle.
  - abort is ignored in IDLE.
- Undefined: port absent, no abort path.

Test Plan:
- w=8,h=4, source always valid → 1 reflesh cycle, then 32 words: rows 0/2 tag 1, rows 1/3 tag 2, word 32 tag 3. Model returns tag 3 later → done pulse, busy falls.
- start with cfg_width=2 (OPE_WIDTH=3) → err_cfg=1, busy stays 0, flt_reflesh never asserted. Next legal start clears err_cfg.
- w=8,h=4, src_valid low 5 cycles before first pixel → 5 INVALID words, no error, frame completes normally.
- w=8,h=4, src_valid dropped at pixel 12 → err_underrun=1, flt_reflesh 1 cycle, IDLE, no done. Next start runs a clean frame.
- DRAIN_MAX=16, model never returns tag 3 → err_timeout=1 after 16 DRAIN cycles, no done.
- With FILTER_CTRL_ABORT_EN: abort at pixel 5 → IDLE next cycle, flt_reflesh pulse, no done/err. Abort in IDLE is a no-op.
